banked_reg_exc: RTL and testbench
=================================

BANKED_REG_EXC -- requirements
Module: banked_reg_exc

Interface
REQ-001 SHALL have parameter SIZE, default 32, data/PC width in bits.
REQ-002 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding on ports A/B/C.
REQ-003 SHALL have ports:
Clk  in  1  clock, all state updates on rising edge
Rst  in  1  reset, synchronous, active-high
Write_Reg  in  1  register write enable
W_Addr  in  4  logical write register R0-R14 (15 ignored)
W_Data  in  SIZE  write data
R_Addr_A / R_Addr_B / R_Addr_C  in  4  logical read addresses
R_Data_A / R_Data_B / R_Data_C  out  SIZE  read data, combinational
Write_PC  in  1  PC write enable
PC_New  in  SIZE  new PC value
PC  out  SIZE  program counter (logical R15)
Write_M  in  1  direct mode change enable
M_New  in  5  requested mode
M  out  5  current mode
Exc_Req  in  1  exception entry request, level
Exc_Mode  in  5  target mode of entry
Exc_Ret  in  1  exception return request, level
Busy  out  1  entry sequence in progress
Mode_Err  out  1  one-cycle pulse, illegal request rejected

Function
REQ-004 Valid modes SHALL be USR 10000, FIQ 10001, IRQ 10010, SVC 10011, ABT 10111, UND 11011, SYS 11111; any other 5-bit value is invalid.
REQ-005 Banking SHALL be: R0-R7 shared by all modes; R8-R12 banked for FIQ only; R13-R14 banked for FIQ, IRQ, SVC, ABT, UND; SYS uses USR bank; 31 physical words total.
REQ-006 Reads SHALL resolve logical address through current M; address 15 returns PC.
REQ-007 With BYPASS=1, a read whose physical target equals the accepted write's physical target SHALL return W_Data in the same cycle; with BYPASS=0 it returns the stored value.
REQ-008 Write_Reg, Write_PC, Write_M SHALL take effect on the next edge, only when FSM is IDLE and no Exc_Req/Exc_Ret is accepted that cycle; otherwise dropped.
REQ-009 Write_M with invalid M_New SHALL be ignored and pulse Mode_Err next cycle.
REQ-010 FSM states SHALL be IDLE, ENTRY1, ENTRY2; priority in IDLE: Exc_Req > Exc_Ret > external writes.
REQ-011 IDLE + Exc_Req with Exc_Mode in {FIQ,IRQ,SVC,ABT,UND} SHALL go to ENTRY1; other Exc_Mode ignored, Mode_Err pulse.
REQ-012 ENTRY1 SHALL write R14 of Exc_Mode bank <= PC and SPSR[Exc_Mode] <= M, then ENTRY2; Exc_Mode latched at acceptance.
REQ-013 ENTRY2 SHALL set M <= latched mode, PC <= vector (UND 0x04, SVC 0x08, ABT 0x10, IRQ 0x18, FIQ 0x1C, zero-extended), then IDLE.
REQ-014 Busy SHALL be high in ENTRY1 and ENTRY2 only; Exc_Req/Exc_Ret during Busy ignored (requester holds level).
REQ-015 IDLE + Exc_Ret SHALL, in one edge, set PC <= current-mode R14, M <= SPSR[M]; in USR/SYS it is ignored with Mode_Err pulse.
REQ-016 Reads during ENTRY1 SHALL use old M; from edge ending ENTRY2, new M.

Reset
REQ-017 On Rst at edge: all 31 words 0, PC 0, M = SVC 10011, all SPSR = 10000, FSM IDLE, Busy 0, Mode_Err 0; Rst overrides any in-flight entry sequence and all writes.

Structure
REQ-018 Mode encodings, vector constants, FSM state encodings SHALL reside in shared package banked_reg_pkg.
REQ-019 Logical-to-physical address mapping SHALL be sub-module bank_map (combinational: M, 4-bit address -> 5-bit physical index).

Verification
REQ-020 Reset; M=USR via Write_M; write R13=0x11; Write_M IRQ; write R13=0x22; read R13 -> 0x22; back to USR -> 0x11.
REQ-021 FIQ write R8=0x5, USR read R8 -> 0 (reset value); SYS write R0=0x9, FIQ read R0 -> 0x9.
REQ-022 USR, PC=0x100, Exc_Req Exc_Mode=IRQ -> Busy 2 cycles, then M=10010, PC=0x18, IRQ R14=0x100, SPSR_IRQ=10000; Exc_Ret -> M=10000, PC=0x100.
REQ-023 Write_Reg same cycle as accepted Exc_Req -> write dropped; Exc_Req with Exc_Mode=10110 -> Mode_Err pulse, state unchanged; Exc_Ret in USR -> Mode_Err.
REQ-024 BYPASS=1: write R3=0x7 while reading R3 on A -> R_Data_A=0x7 same cycle; BYPASS=0 -> old value.
REQ-025 Rst asserted in ENTRY1 -> next cycle full reset state, Busy 0, IRQ R14 = 0.

Source files
------------

// File: rtl/banked_reg_pkg.sv
// Shared encodings for the banked register file: processor modes, exception
// vectors, physical bank layout and the exception-entry FSM states.
package banked_reg_pkg;

  typedef enum logic [4:0] {
    MODE_USR = 5'b10000,
    MODE_FIQ = 5'b10001,
    MODE_IRQ = 5'b10010,
    MODE_SVC = 5'b10011,
    MODE_ABT = 5'b10111,
    MODE_UND = 5'b11011,
    MODE_SYS = 5'b11111
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTRY1 = 2'd1,
    ST_ENTRY2 = 2'd2
  } state_e;

  localparam logic [7:0] VEC_UND = 8'h04;
  localparam logic [7:0] VEC_SVC = 8'h08;
  localparam logic [7:0] VEC_ABT = 8'h10;
  localparam logic [7:0] VEC_IRQ = 8'h18;
  localparam logic [7:0] VEC_FIQ = 8'h1C;

  // Physical layout: 0-14 shared/USR view, then the private banks; PC is word 30.
  localparam int         NUM_PHYS    = 30;
  localparam logic [4:0] PHYS_FIQ_HI = 5'd15;
  localparam logic [4:0] PHYS_FIQ_SP = 5'd20;
  localparam logic [4:0] PHYS_IRQ_SP = 5'd22;
  localparam logic [4:0] PHYS_SVC_SP = 5'd24;
  localparam logic [4:0] PHYS_ABT_SP = 5'd26;
  localparam logic [4:0] PHYS_UND_SP = 5'd28;
  localparam logic [4:0] PHYS_PC     = 5'd30;

  function automatic logic is_valid_mode(input logic [4:0] m);
    case (m)
      MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC,
      MODE_ABT, MODE_UND, MODE_SYS: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  function automatic logic is_exc_mode(input logic [4:0] m);
    case (m)
      MODE_FIQ, MODE_IRQ, MODE_SVC, MODE_ABT, MODE_UND: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] exc_vector(input logic [4:0] m);
    case (m)
      MODE_UND: return VEC_UND;
      MODE_SVC: return VEC_SVC;
      MODE_ABT: return VEC_ABT;
      MODE_IRQ: return VEC_IRQ;
      MODE_FIQ: return VEC_FIQ;
      default:  return 8'h00;
    endcase
  endfunction

  function automatic logic [2:0] spsr_idx(input logic [4:0] m);
    case (m)
      MODE_FIQ: return 3'd0;
      MODE_IRQ: return 3'd1;
      MODE_SVC: return 3'd2;
      MODE_ABT: return 3'd3;
      MODE_UND: return 3'd4;
      default:  return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/banked_reg_exc_bank_map.sv
// Logical-to-physical register index translation for a given processor mode.
module bank_map
  import banked_reg_pkg::*;
(
  input  logic [4:0] i_mode,
  input  logic [3:0] i_addr,
  output logic [4:0] o_phys
);

  logic [4:0] w_sp_off;
  logic [4:0] w_fiq_off;

  assign w_sp_off  = {4'b0000, (i_addr == 4'd14)};
  assign w_fiq_off = {1'b0, i_addr} - 5'd8;

  always_comb begin
    // NOTE: default first so every path assigns o_phys and no latch is inferred.
    o_phys = {1'b0, i_addr};
    if (i_addr == 4'd15) begin
      o_phys = PHYS_PC;
    end else if (i_addr >= 4'd8 && i_addr <= 4'd12) begin
      if (i_mode == MODE_FIQ) o_phys = PHYS_FIQ_HI + w_fiq_off;
    end else if (i_addr >= 4'd13) begin
      case (i_mode)
        MODE_FIQ: o_phys = PHYS_FIQ_SP + w_sp_off;
        MODE_IRQ: o_phys = PHYS_IRQ_SP + w_sp_off;
        MODE_SVC: o_phys = PHYS_SVC_SP + w_sp_off;
        MODE_ABT: o_phys = PHYS_ABT_SP + w_sp_off;
        MODE_UND: o_phys = PHYS_UND_SP + w_sp_off;
        default:  o_phys = {1'b0, i_addr};
      endcase
    end
  end

endmodule

// File: rtl/banked_reg_exc.sv
// Mode-banked register file with PC, SPSRs and a two-cycle exception-entry
// sequencer; reads are combinational, optionally forwarding the same-cycle write.
module banked_reg_exc
  import banked_reg_pkg::*;
#(
  parameter int SIZE   = 32,
  parameter int BYPASS = 1
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Write_Reg,
  input  logic [3:0]      W_Addr,
  input  logic [SIZE-1:0] W_Data,
  input  logic [3:0]      R_Addr_A,
  input  logic [3:0]      R_Addr_B,
  input  logic [3:0]      R_Addr_C,
  output logic [SIZE-1:0] R_Data_A,
  output logic [SIZE-1:0] R_Data_B,
  output logic [SIZE-1:0] R_Data_C,
  input  logic            Write_PC,
  input  logic [SIZE-1:0] PC_New,
  output logic [SIZE-1:0] PC,
  input  logic            Write_M,
  input  logic [4:0]      M_New,
  output logic [4:0]      M,
  input  logic            Exc_Req,
  input  logic [4:0]      Exc_Mode,
  input  logic            Exc_Ret,
  output logic            Busy,
  output logic            Mode_Err
);

  state_e          r_state;
  state_e          w_next_state;
  logic [4:0]      r_mode;
  logic [4:0]      r_exc_mode;
  logic [SIZE-1:0] r_pc;
  logic [SIZE-1:0] r_regs [NUM_PHYS];
  logic [4:0]      r_spsr [5];
  logic            r_mode_err;

  logic            w_exc_accept;
  logic            w_ret_accept;
  logic            w_ext_ok;
  logic            w_err;
  logic            w_reg_we;
  logic [4:0]      w_wphys;
  logic [4:0]      w_cur_r14;
  logic [4:0]      w_exc_r14;

  // Exception requests outrank returns, which outrank ordinary writes.
  always_comb begin
    w_next_state = r_state;
    w_exc_accept = 1'b0;
    w_ret_accept = 1'b0;
    w_ext_ok     = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Exc_Req) begin
          if (is_exc_mode(Exc_Mode)) begin
            w_exc_accept = 1'b1;
            w_next_state = ST_ENTRY1;
          end else begin
            w_err = 1'b1;
          end
        end else if (Exc_Ret) begin
          if (is_exc_mode(r_mode)) w_ret_accept = 1'b1;
          else                     w_err        = 1'b1;
        end else begin
          w_ext_ok = 1'b1;
          if (Write_M && !is_valid_mode(M_New)) w_err = 1'b1;
        end
      end
      ST_ENTRY1: w_next_state = ST_ENTRY2;
      ST_ENTRY2: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    // NOTE: state elements use non-blocking assignments so every register samples pre-edge values.
    if (Rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  assign w_reg_we = w_ext_ok && Write_Reg && (W_Addr != 4'd15);

  bank_map u_map_w   (.i_mode(r_mode),     .i_addr(W_Addr), .o_phys(w_wphys));
  bank_map u_map_ret (.i_mode(r_mode),     .i_addr(4'd14),  .o_phys(w_cur_r14));
  bank_map u_map_exc (.i_mode(r_exc_mode), .i_addr(4'd14),  .o_phys(w_exc_r14));

  logic [3:0]      w_raddr [3];
  logic [4:0]      w_rphys [3];
  logic [SIZE-1:0] w_rdata [3];

  assign w_raddr[0] = R_Addr_A;
  assign w_raddr[1] = R_Addr_B;
  assign w_raddr[2] = R_Addr_C;

  for (genvar g = 0; g < 3; g++) begin : g_rd
    bank_map u_map_r (.i_mode(r_mode), .i_addr(w_raddr[g]), .o_phys(w_rphys[g]));

    always_comb begin
      if (w_raddr[g] == 4'd15)
        w_rdata[g] = r_pc;
      else if ((BYPASS != 0) && w_reg_we && (w_rphys[g] == w_wphys))
        w_rdata[g] = W_Data;
      else
        w_rdata[g] = r_regs[w_rphys[g]];
    end
  end

  assign R_Data_A = w_rdata[0];
  assign R_Data_B = w_rdata[1];
  assign R_Data_C = w_rdata[2];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      // NOTE: the register file is architecturally defined to clear on reset, so it is built from flops, not RAM.
      for (int i = 0; i < NUM_PHYS; i++) r_regs[i] <= '0;
      for (int i = 0; i < 5; i++)        r_spsr[i] <= MODE_USR;
      r_pc       <= '0;
      r_mode     <= MODE_SVC;
      r_exc_mode <= MODE_SVC;
      r_mode_err <= 1'b0;
    end else begin
      r_mode_err <= w_err;
      if (w_exc_accept) r_exc_mode <= Exc_Mode;
      if (w_reg_we)     r_regs[w_wphys] <= W_Data;
      if (w_ext_ok && Write_PC) r_pc <= PC_New;
      if (w_ext_ok && Write_M && is_valid_mode(M_New)) r_mode <= M_New;
      if (w_ret_accept) begin
        r_pc   <= r_regs[w_cur_r14];
        r_mode <= r_spsr[spsr_idx(r_mode)];
      end
      if (r_state == ST_ENTRY1) begin
        r_regs[w_exc_r14]            <= r_pc;
        r_spsr[spsr_idx(r_exc_mode)] <= r_mode;
      end
      if (r_state == ST_ENTRY2) begin
        r_mode <= r_exc_mode;
        r_pc   <= SIZE'(exc_vector(r_exc_mode));
      end
    end
  end

  assign PC       = r_pc;
  assign M        = r_mode;
  assign Busy     = (r_state != ST_IDLE);
  assign Mode_Err = r_mode_err;

endmodule

// File: tb/tb_banked_reg_exc.sv
// Directed bench for banked_reg_exc: a mode/bank-level reference model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_banked_reg_exc;

  localparam logic [4:0] USR = 5'b10000, FIQ = 5'b10001, IRQ = 5'b10010,
                         SVC = 5'b10011, ABT = 5'b10111, UND = 5'b11011,
                         SYS = 5'b11111;

  logic        Clk = 1'b0;
  logic        Rst, Write_Reg, Write_PC, Write_M, Exc_Req, Exc_Ret;
  logic [3:0]  W_Addr, R_Addr_A, R_Addr_B, R_Addr_C;
  logic [31:0] W_Data, PC_New;
  logic [4:0]  M_New, Exc_Mode;

  logic [31:0] R_Data_A, R_Data_B, R_Data_C, PC;
  logic [4:0]  M;
  logic        Busy, Mode_Err;
  logic [31:0] nb_R_Data_A, nb_R_Data_B, nb_R_Data_C, nb_PC;
  logic [4:0]  nb_M;
  logic        nb_Busy, nb_Mode_Err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  banked_reg_exc #(.SIZE(32), .BYPASS(1)) dut (
    .Clk(Clk), .Rst(Rst), .Write_Reg(Write_Reg), .W_Addr(W_Addr), .W_Data(W_Data),
    .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .R_Addr_C(R_Addr_C),
    .R_Data_A(R_Data_A), .R_Data_B(R_Data_B), .R_Data_C(R_Data_C),
    .Write_PC(Write_PC), .PC_New(PC_New), .PC(PC),
    .Write_M(Write_M), .M_New(M_New), .M(M),
    .Exc_Req(Exc_Req), .Exc_Mode(Exc_Mode), .Exc_Ret(Exc_Ret),
    .Busy(Busy), .Mode_Err(Mode_Err)
  );

  banked_reg_exc #(.SIZE(32), .BYPASS(0)) dut_nb (
    .Clk(Clk), .Rst(Rst), .Write_Reg(Write_Reg), .W_Addr(W_Addr), .W_Data(W_Data),
    .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .R_Addr_C(R_Addr_C),
    .R_Data_A(nb_R_Data_A), .R_Data_B(nb_R_Data_B), .R_Data_C(nb_R_Data_C),
    .Write_PC(Write_PC), .PC_New(PC_New), .PC(nb_PC),
    .Write_M(Write_M), .M_New(M_New), .M(nb_M),
    .Exc_Req(Exc_Req), .Exc_Mode(Exc_Mode), .Exc_Ret(Exc_Ret),
    .Busy(nb_Busy), .Mode_Err(nb_Mode_Err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: banks indexed by owning mode ----------------
  logic [31:0] m_reg [6][15];   // bank 0 = USR/SYS view, 1..5 = FIQ IRQ SVC ABT UND
  logic [4:0]  m_spsr [6];
  logic [31:0] m_pc;
  logic [4:0]  m_mode, m_exc;
  int          m_left;          // entry cycles still to run
  bit          m_err, m_valid = 0;

  function automatic int mbank(input logic [4:0] m);
    case (m)
      FIQ: return 1;  IRQ: return 2;  SVC: return 3;
      ABT: return 4;  UND: return 5;  default: return 0;
    endcase
  endfunction

  function automatic int bank_of(input logic [4:0] m, input int r);
    if (r < 8)  return 0;
    if (r < 13) return (m == FIQ) ? 1 : 0;
    return mbank(m);
  endfunction

  function automatic logic [31:0] vec(input logic [4:0] m);
    case (m)
      UND: return 32'h04;  SVC: return 32'h08;  ABT: return 32'h10;
      IRQ: return 32'h18;  FIQ: return 32'h1C;  default: return 32'h0;
    endcase
  endfunction

  function automatic bit write_taken();
    return (m_left == 0) && !Exc_Req && !Exc_Ret && Write_Reg && (W_Addr != 4'd15);
  endfunction

  function automatic logic [31:0] exp_read(input logic [3:0] a, input bit byp);
    if (a == 4'd15) return m_pc;
    if (byp && write_taken() && a == W_Addr) return W_Data;
    return m_reg[bank_of(m_mode, int'(a))][a];
  endfunction

  task automatic model_step();
    logic [4:0] nm;
    if (Rst) begin
      for (int b = 0; b < 6; b++) begin
        m_spsr[b] = USR;
        for (int r = 0; r < 15; r++) m_reg[b][r] = '0;
      end
      m_pc = '0; m_mode = SVC; m_exc = SVC; m_left = 0; m_err = 0; m_valid = 1;
    end else if (m_valid) begin
      m_err = 0;
      if (m_left == 2) begin
        m_reg[bank_of(m_exc, 14)][14] = m_pc;
        m_spsr[mbank(m_exc)] = m_mode;
        m_left = 1;
      end else if (m_left == 1) begin
        m_mode = m_exc; m_pc = vec(m_exc); m_left = 0;
      end else if (Exc_Req) begin
        if (Exc_Mode inside {FIQ, IRQ, SVC, ABT, UND}) begin
          m_exc = Exc_Mode; m_left = 2;
        end else m_err = 1;
      end else if (Exc_Ret) begin
        if (m_mode inside {USR, SYS}) m_err = 1;
        else begin
          nm     = m_spsr[mbank(m_mode)];
          m_pc   = m_reg[bank_of(m_mode, 14)][14];
          m_mode = nm;
        end
      end else begin
        if (Write_Reg && W_Addr != 4'd15)
          m_reg[bank_of(m_mode, int'(W_Addr))][W_Addr] = W_Data;
        if (Write_PC) m_pc = PC_New;
        if (Write_M) begin
          if (M_New inside {USR, FIQ, IRQ, SVC, ABT, UND, SYS}) m_mode = M_New;
          else m_err = 1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge Clk);
    model_step();
  end

  // Compare process: every cycle once the model has seen reset.
  initial forever begin
    @(negedge Clk);
    #2;
    if (m_valid) begin
      check("PC",    PC,          m_pc);
      check("M",     {27'b0, M},  {27'b0, m_mode});
      check("Busy",  {31'b0, Busy},     {31'b0, (m_left != 0)});
      check("ModeErr", {31'b0, Mode_Err}, {31'b0, m_err});
      check("A",     R_Data_A,    exp_read(R_Addr_A, 1));
      check("B",     R_Data_B,    exp_read(R_Addr_B, 1));
      check("C",     R_Data_C,    exp_read(R_Addr_C, 1));
      check("nbA",   nb_R_Data_A, exp_read(R_Addr_A, 0));
      check("nbB",   nb_R_Data_B, exp_read(R_Addr_B, 0));
      check("nbC",   nb_R_Data_C, exp_read(R_Addr_C, 0));
      check("nbPC",  nb_PC,       m_pc);
      check("nbM",   {27'b0, nb_M}, {27'b0, m_mode});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic clear_inputs();
    Rst = 0; Write_Reg = 0; W_Addr = 0; W_Data = 0; Write_PC = 0; PC_New = 0;
    Write_M = 0; M_New = USR; Exc_Req = 0; Exc_Mode = USR; Exc_Ret = 0;
    R_Addr_A = 4'd0; R_Addr_B = 4'd13; R_Addr_C = 4'd14;
  endtask

  task automatic next();
    @(negedge Clk);
    clear_inputs();
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    Write_Reg = 1; W_Addr = a; W_Data = d;
  endtask

  task automatic set_m(input logic [4:0] m);
    Write_M = 1; M_New = m;
  endtask

  initial begin
    clear_inputs();
    Rst = 1;
    repeat (2) @(negedge Clk);
    next();
    #3;
    check("rst_PC", PC, 32'h0);
    check("rst_M", {27'b0, M}, {27'b0, SVC});
    check("rst_Busy", {31'b0, Busy}, 32'h0);
    check("rst_ModeErr", {31'b0, Mode_Err}, 32'h0);
    check("rst_R0", R_Data_A, 32'h0);

    // Banked R13 between USR and IRQ
    set_m(USR);
    next(); #3 check("usr_M", {27'b0, M}, {27'b0, USR});
    wr(4'd13, 32'h11);
    next(); set_m(IRQ);
    next(); #3 check("irq_M", {27'b0, M}, {27'b0, IRQ});
    wr(4'd13, 32'h22);
    next(); R_Addr_A = 13; set_m(USR); #3 check("irq_R13", R_Data_A, 32'h22);
    next(); R_Addr_A = 13; #3 check("usr_R13", R_Data_A, 32'h11);

    // FIQ-private R8, shared R0
    set_m(FIQ);
    next(); wr(4'd8, 32'h5);
    next(); set_m(USR);
    next(); R_Addr_A = 8; set_m(SYS); #3 check("usr_R8", R_Data_A, 32'h0);
    next(); wr(4'd0, 32'h9);
    next(); set_m(FIQ);
    next(); R_Addr_A = 0; #3 check("fiq_R0", R_Data_A, 32'h9);

    // Forwarding vs. stored value
    next(); wr(4'd3, 32'h7); R_Addr_A = 3;
    #3 check("byp_R3", R_Data_A, 32'h7);
    check("nobyp_R3", nb_R_Data_A, 32'h0);
    next(); R_Addr_A = 3; #3 check("after_R3", nb_R_Data_A, 32'h7);

    // IRQ entry and return
    next(); set_m(USR); Write_PC = 1; PC_New = 32'h100;
    next(); #3 check("pre_PC", PC, 32'h100);
    Exc_Req = 1; Exc_Mode = IRQ;
    next(); Exc_Req = 1; Exc_Mode = IRQ; R_Addr_A = 13;
    #3 check("e1_Busy", {31'b0, Busy}, 32'h1);
    check("e1_oldM_R13", R_Data_A, 32'h11);
    next(); Exc_Req = 1; Exc_Mode = IRQ; R_Addr_A = 14;
    #3 check("e2_Busy", {31'b0, Busy}, 32'h1);
    check("e2_M", {27'b0, M}, {27'b0, USR});
    next(); R_Addr_A = 14; R_Addr_B = 13;
    #3 check("irq_Busy", {31'b0, Busy}, 32'h0);
    check("irq_M2", {27'b0, M}, {27'b0, IRQ});
    check("irq_vec", PC, 32'h18);
    check("irq_R14", R_Data_A, 32'h100);
    check("irq_R13b", R_Data_B, 32'h22);
    Exc_Ret = 1;
    next(); #3 check("ret_M", {27'b0, M}, {27'b0, USR});
    check("ret_PC", PC, 32'h100);

    // Write dropped under an accepted request
    wr(4'd5, 32'hAB); Exc_Req = 1; Exc_Mode = IRQ;
    next(); next();
    next(); R_Addr_A = 5; #3 check("drop_R5", R_Data_A, 32'h0);
    Exc_Ret = 1;
    next(); Exc_Req = 1; Exc_Mode = 5'b10110;
    next(); #3 check("badexc_err", {31'b0, Mode_Err}, 32'h1);
    check("badexc_Busy", {31'b0, Busy}, 32'h0);
    check("badexc_PC", PC, 32'h100);
    Exc_Ret = 1;
    next(); #3 check("usrret_err", {31'b0, Mode_Err}, 32'h1);
    check("usrret_M", {27'b0, M}, {27'b0, USR});
    set_m(5'b10100);
    next(); #3 check("badm_err", {31'b0, Mode_Err}, 32'h1);
    check("badm_M", {27'b0, M}, {27'b0, USR});
    next(); #3 check("err_clear", {31'b0, Mode_Err}, 32'h0);

    // SVC then nested FIQ entry, R15 write ignored
    Exc_Req = 1; Exc_Mode = SVC;
    next(); next();
    next(); R_Addr_A = 14; #3 check("svc_vec", PC, 32'h08);
    check("svc_R14", R_Data_A, 32'h100);
    wr(4'd15, 32'hDEAD);
    next(); #3 check("r15_ign", PC, 32'h08);
    Exc_Req = 1; Exc_Mode = FIQ;
    next(); next();
    next(); R_Addr_A = 14; #3 check("fiq_vec", PC, 32'h1C);
    check("fiq_R14", R_Data_A, 32'h08);
    Exc_Ret = 1;
    next(); #3 check("fret_M", {27'b0, M}, {27'b0, SVC});
    check("fret_PC", PC, 32'h08);

    // Reset in the middle of an entry
    set_m(USR);
    next(); Exc_Req = 1; Exc_Mode = IRQ;
    next(); Exc_Req = 1; Exc_Mode = IRQ; Rst = 1;
    #3 check("mid_Busy", {31'b0, Busy}, 32'h1);
    next(); #3 check("rr_Busy", {31'b0, Busy}, 32'h0);
    check("rr_M", {27'b0, M}, {27'b0, SVC});
    check("rr_PC", PC, 32'h0);
    check("rr_ModeErr", {31'b0, Mode_Err}, 32'h0);
    set_m(IRQ);
    next(); R_Addr_A = 14; #3 check("rr_irqR14", R_Data_A, 32'h0);
    next(); next();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
